// File: rtl/sdivmod_pkg.sv
// Shared divider-family definitions: FSM state encodings and result flag bit positions.
package sdivmod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int FLAG_W   = 2;
   localparam int FLAG_DZ  = 0;
   localparam int FLAG_OVF = 1;

   function automatic logic [FLAG_W-1:0] mk_flags(input logic dz, input logic ovf);
      logic [FLAG_W-1:0] f;
      f = '0;
      f[FLAG_DZ]  = dz;
      f[FLAG_OVF] = ovf;
      return f;
   endfunction

endpackage

// File: rtl/sdivmod_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module divmod_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_dvs,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_dvs};
   // Remainder is always below the divisor, so the MSB of the difference is a clean borrow.
   assign o_qbit  = ~w_diff[WIDTH];
   assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/sdivmod.sv
// Iterative signed/unsigned divider with remainder: one restoring step per cycle,
// sign fix-up afterwards, and a ready/valid handshake on both sides.
module sdivmod
   import sdivmod_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_div,
   output logic [WIDTH-1:0] out_mod,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz,
   output logic             out_ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             r_state,     w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
   logic [WIDTH-1:0]   r_rem,       w_rem_nxt;
   logic [WIDTH-1:0]   r_quo,       w_quo_nxt;
   logic [WIDTH-1:0]   r_dvs,       w_dvs_nxt;
   logic               r_neg_q,     w_neg_q_nxt;
   logic               r_neg_r,     w_neg_r_nxt;
   logic               r_ovf_pend,  w_ovf_pend_nxt;
   logic               r_in_ready,  w_in_ready_nxt;
   logic               r_out_valid, w_out_valid_nxt;
   logic [WIDTH-1:0]   r_div,       w_div_nxt;
   logic [WIDTH-1:0]   r_mod,       w_mod_nxt;
   logic [TAG_W-1:0]   r_tag,       w_tag_nxt;
   logic [FLAG_W-1:0]  r_flags,     w_flags_nxt;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_min_neg;
   logic [WIDTH-1:0]   w_step_rem;
   logic               w_step_qbit;

   assign w_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_abs_a   = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
   assign w_abs_b   = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;

   divmod_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_dvs  (r_dvs),
      .i_bit  (r_quo[WIDTH-1]),
      .o_rem  (w_step_rem),
      .o_qbit (w_step_qbit)
   );

   // Next-state and next-output logic for the whole datapath.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rem_nxt       = r_rem;
      w_quo_nxt       = r_quo;
      w_dvs_nxt       = r_dvs;
      w_neg_q_nxt     = r_neg_q;
      w_neg_r_nxt     = r_neg_r;
      w_ovf_pend_nxt  = r_ovf_pend;
      w_out_valid_nxt = r_out_valid;
      w_div_nxt       = r_div;
      w_mod_nxt       = r_mod;
      w_tag_nxt       = r_tag;
      w_flags_nxt     = r_flags;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_tag_nxt = in_tag;
               if (in_b == '0) begin
                  w_state_nxt     = ST_DONE;
                  w_div_nxt       = '1;
                  w_mod_nxt       = in_a;
                  w_flags_nxt     = mk_flags(1'b1, 1'b0);
                  w_out_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt    = ST_CALC;
                  w_cnt_nxt      = '0;
                  w_rem_nxt      = '0;
                  w_quo_nxt      = w_abs_a;
                  w_dvs_nxt      = w_abs_b;
                  w_neg_q_nxt    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  w_neg_r_nxt    = in_signed & in_a[WIDTH-1];
                  w_ovf_pend_nxt = in_signed && (in_a == w_min_neg) && (in_b == '1);
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CALC: begin
            w_rem_nxt = w_step_rem;
            w_quo_nxt = {r_quo[WIDTH-2:0], w_step_qbit};
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_state_nxt = ST_FIX;
            end else begin
               w_state_nxt = ST_CALC;
            end
         end
         ST_FIX: begin
            // Truncation toward zero: remainder follows the dividend sign.
            w_div_nxt       = r_neg_q ? (~r_quo + 1'b1) : r_quo;
            w_mod_nxt       = r_neg_r ? (~r_rem + 1'b1) : r_rem;
            w_flags_nxt     = mk_flags(1'b0, r_ovf_pend);
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
               w_flags_nxt     = '0;
               w_cnt_nxt       = '0;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
            w_flags_nxt     = '0;
         end
      endcase
      w_in_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   // All state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_ovf_pend  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_div       <= '0;
         r_mod       <= '0;
         r_tag       <= '0;
         r_flags     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rem       <= w_rem_nxt;
         r_quo       <= w_quo_nxt;
         r_dvs       <= w_dvs_nxt;
         r_neg_q     <= w_neg_q_nxt;
         r_neg_r     <= w_neg_r_nxt;
         r_ovf_pend  <= w_ovf_pend_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_div       <= w_div_nxt;
         r_mod       <= w_mod_nxt;
         r_tag       <= w_tag_nxt;
         r_flags     <= w_flags_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_div   = r_div;
   assign out_mod   = r_mod;
   assign out_tag   = r_tag;
   assign out_dz    = r_flags[FLAG_DZ];
   assign out_ovf   = r_flags[FLAG_OVF];

endmodule

// File: tb/tb_sdivmod.sv
// Directed scoreboard bench for sdivmod at WIDTH=8, TAG_W=4.
module tb_sdivmod;

   localparam int W  = 8;
   localparam int TW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_div;
   logic [W-1:0]  out_mod;
   logic [TW-1:0] out_tag;
   logic          out_dz;
   logic          out_ovf;

   typedef struct {
      logic [W-1:0]  div;
      logic [W-1:0]  mod;
      logic [TW-1:0] tag;
      logic          dz;
      logic          ovf;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;

   sdivmod #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_div   (out_div),
      .out_mod   (out_mod),
      .out_tag   (out_tag),
      .out_dz    (out_dz),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request, push its expected result, then scramble the inputs.
   task automatic send(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
      exp_t        e;
      int          sa, sb_i, q, r;
      logic [31:0] qv, rv;
      e.tag = tag; e.dz = 1'b0; e.ovf = 1'b0; e.lat = W + 2;
      if (b == 8'h00) begin
         e.div = 8'hFF; e.mod = a; e.dz = 1'b1; e.lat = 1;
      end else if (sg && a == 8'h80 && b == 8'hFF) begin
         e.div = 8'h80; e.mod = 8'h00; e.ovf = 1'b1;
      end else if (sg) begin
         sa = int'($signed(a)); sb_i = int'($signed(b));
         q = sa / sb_i; r = sa % sb_i;
         qv = q; rv = r;
         e.div = qv[7:0]; e.mod = rv[7:0];
      end else begin
         q = int'(a) / int'(b); r = int'(a) % int'(b);
         qv = q; rv = r;
         e.div = qv[7:0]; e.mod = rv[7:0];
      end
      sb.push_back(e);
      @(negedge clk);
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_signed = sg; in_a = a; in_b = b; in_tag = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_signed = ~sg;
      in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
   endtask

   // Wait for a result, compare it against the scoreboard, optionally stall, then consume.
   task automatic recv(input int hold);
      exp_t e;
      int   n;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("div", {24'd0, out_div}, {24'd0, e.div});
      chk("mod", {24'd0, out_mod}, {24'd0, e.mod});
      chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
      chk("dz", {31'd0, out_dz}, {31'd0, e.dz});
      chk("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_div", {24'd0, out_div}, {24'd0, e.div});
         chk("hold_mod", {24'd0, out_mod}, {24'd0, e.mod});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
      chk("valid_after_consume", {31'd0, out_valid}, 32'd0);
      chk("flags_after_consume", {30'd0, out_dz, out_ovf}, 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_outputs", {out_valid, out_dz, out_ovf, out_tag, out_div, out_mod}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      send(1'b0, 8'd100, 8'd7, 4'd3);    recv(0);
      send(1'b1, 8'hF9, 8'h02, 4'd5);    recv(0);
      send(1'b1, 8'h07, 8'hFE, 4'd6);    recv(0);
      send(1'b1, 8'h80, 8'hFF, 4'd7);    recv(0);
      send(1'b0, 8'h80, 8'hFF, 4'd8);    recv(0);
      send(1'b0, 8'd5, 8'd0, 4'd9);      recv(0);
      send(1'b1, 8'hFB, 8'd0, 4'd10);    recv(0);
      send(1'b1, 8'h80, 8'h01, 4'd11);   recv(0);
      send(1'b0, 8'd255, 8'd16, 4'd12);  recv(3);
      for (int k = 0; k < 6; k++) begin
         send(k[0], 8'($urandom), 8'($urandom_range(1, 255)), 4'(k));
         recv(k % 2);
      end

      // Reset three cycles into the calculation abandons the operation.
      send(1'b0, 8'd200, 8'd3, 4'd4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_outputs", {out_valid, out_dz, out_ovf, out_tag, out_div, out_mod}, 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", {31'd0, out_valid}, 32'd0);
      end
      send(1'b0, 8'd9, 8'd3, 4'd2);      recv(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdivmod.md
SDIVMOD -- requirements
Module: sdivmod

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits, >= 2.
REQ-002 Parameter: TAG_W, 4, width of the opaque tag carried from request to result, >= 1.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: in_signed  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-008 Port: in_a / in_b  input  WIDTH  dividend / divisor.
REQ-009 Port: in_tag  input  TAG_W  request tag.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: out_div / out_mod  output  WIDTH  quotient / remainder.
REQ-013 Port: out_tag  output  TAG_W  tag of the accepted request.
REQ-014 Port: out_dz / out_ovf  output  1  divide-by-zero / signed-overflow flags.

Function
REQ-015 Request SHALL be accepted on a rising edge with in_valid && in_ready; operands, mode and tag are captured on that edge.
REQ-016 in_ready SHALL be high only in IDLE; there SHALL be one request in flight, no overlap.
REQ-017 States SHALL be IDLE, CALC, FIX, DONE.
REQ-018 IDLE -> CALC on acceptance with in_b != 0, capturing |a| and |b| (magnitudes when in_signed, raw values otherwise) and latching result signs.
REQ-019 CALC SHALL perform one restoring shift-subtract step per cycle, exactly WIDTH cycles, counted by an internal counter; then -> FIX.
REQ-020 FIX SHALL apply signs: quotient negated when operand signs differ, remainder takes the dividend sign (truncation toward zero); then -> DONE.
REQ-021 Normal latency: out_valid SHALL rise WIDTH+2 edges after the accept edge.
REQ-022 Divide-by-zero: IDLE -> DONE directly; out_div = all ones, out_mod = in_a, out_dz = 1; out_valid one edge after acceptance; regardless of in_signed.
REQ-023 Signed overflow (in_signed, a = most-negative, b = -1): normal path and latency; out_div = most-negative, out_mod = 0, out_ovf = 1.
REQ-024 In DONE, out_valid SHALL stay high and all out_* SHALL stay stable until out_valid && out_ready; then -> IDLE.
REQ-025 In DONE with out_ready high, the result SHALL be consumed on that edge and in_ready SHALL rise the following cycle (no same-cycle re-accept).
REQ-026 Unsigned mode SHALL satisfy a = div*b + mod with mod < b; signed mode |mod| < |b| with a = div*b + mod mod 2^WIDTH.
REQ-027 in_* changes after acceptance SHALL have no effect on the in-flight operation.
REQ-028 out_dz and out_ovf SHALL be 0 whenever out_valid is 0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready = 1, out_valid = 0, out_div = 0, out_mod = 0, out_tag = 0, out_dz = 0, out_ovf = 0, step counter 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no result; the first acceptance after release SHALL behave as from power-up.
REQ-031 Reset release is synchronised externally; the block SHALL treat the first edge after release as normal operation.

Structure
REQ-032 State encodings and flag bit positions SHALL live in the shared defines file used by the divider family.
REQ-033 One combinational sub-module, divmod_step, SHALL compute a single restoring step (partial remainder, divisor, dividend bit -> next remainder, quotient bit), parametrised by WIDTH.
REQ-034 All registers SHALL be in one clocked always block with async reset; next-state logic in one combinational block.

Verification (WIDTH=8, TAG_W=4)
REQ-035 Unsigned 100/7, tag 3 -> div 14, mod 2, tag 3, flags 0, out_valid 10 edges after accept.
REQ-036 Signed -7/2 (0xF9/0x02) -> div 0xFD, mod 0xFF; signed 7/-2 -> div 0xFD, mod 0x01.
REQ-037 Signed 0x80/0xFF -> div 0x80, mod 0x00, out_ovf 1; unsigned 0x80/0xFF -> div 0, mod 0x80, flags 0.
REQ-038 5/0 -> div 0xFF, mod 5, out_dz 1, out_valid 1 edge after accept.
REQ-039 out_ready low 3 cycles in DONE -> outputs stable, in_ready 0; raise out_ready -> in_ready 1 next cycle.
REQ-040 rst_n pulsed low 3 cycles into CALC -> outputs zero immediately, no out_valid; next request 9/3 -> div 3, mod 0.
